hazard_unit: RTL and testbench

- Hazard controller for the 5-stage pipelined MIPS core (IF/ID/EX/MEM/WB).
- Keeps its own shadow pipeline of destination-register info for the EX, MEM and WB slots, and receives decoded source/destination info from ID.
- Drives the pipeline-register enables and flushes (stall, IF/ID flush, ID/EX bubble) and the EX-stage forwarding selects.
- Sits beside the datapath and is the single source of the stall signal for the PC and IF_ID flops.

---
 rtl/hazard_unit.sv | 170 +++++++++++++++++
 tb/tb_hazard_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// hazard_unit
//   Hazard controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
//   It keeps a shadow copy of destination-register info for the EX, MEM and
//   WB slots, and from that drives the stall, flush, freeze and EX-stage
//   forwarding selects. It is the only source of stall for PC and IF/ID.
//
//   Optional feature macro: HAZARD_PERF_EN adds saturating performance
//   counters stall_cnt / flush_cnt / freeze_cnt (CNT_W bits each).
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   id_*              decoded info of the instruction currently in ID
//   ex_pcsrc          branch resolved taken in EX
//   mem_busy          data memory not ready (freezes the whole pipeline)
//   stall             hold PC and IF/ID
//   freeze            hold every pipeline register
//   if_id_flush       clear IF/ID at the next edge
//   id_ex_flush       load a bubble into ID/EX at the next edge
//   fwd_a, fwd_b      EX operand source: 00 regfile, 01 WB, 10 MEM aluout
module hazard_unit #(
  parameter int RA_W  = 5
`ifdef HAZARD_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            id_use_rs,
  input  logic            id_use_rt,
  input  logic            id_regwrite,
  input  logic            id_memtoreg,
  input  logic [RA_W-1:0] id_writereg,
  input  logic            id_jump,
  input  logic            ex_pcsrc,
  input  logic            mem_busy,
  output logic            stall,
  output logic            freeze,
  output logic            if_id_flush,
  output logic            id_ex_flush,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b
`ifdef HAZARD_PERF_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] flush_cnt
  , output logic [CNT_W-1:0] freeze_cnt
`endif
);

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rs;
    logic [RA_W-1:0] rt;
    logic            regwrite;
    logic            memtoreg;
    logic [RA_W-1:0] dst;
  } ex_slot_t;

  typedef struct packed {
    logic            valid;
    logic            regwrite;
    logic            memtoreg;
    logic [RA_W-1:0] dst;
  } wr_slot_t;

  ex_slot_t ex_q, ex_d;
  wr_slot_t mem_q, mem_d, wb_q, wb_d;

  logic ex_live, mem_live, wb_live, load_use;

  // Operand source select. A load sitting in MEM has no data yet, so it is
  // skipped and the value is picked up from WB one cycle later instead.
  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] src,
                                         input logic mem_ok, input wr_slot_t m,
                                         input logic wb_ok,  input wr_slot_t w);
    logic [1:0] sel;
    sel = 2'b00;
    if (mem_ok && !m.memtoreg && m.dst == src)
      sel = 2'b10;
    else if (wb_ok && w.dst == src)
      sel = 2'b01;
    return sel;
  endfunction

  always_comb begin
    ex_live  = ex_q.valid  && ex_q.regwrite  && (ex_q.dst  != '0);
    mem_live = mem_q.valid && mem_q.regwrite && (mem_q.dst != '0);
    wb_live  = wb_q.valid  && wb_q.regwrite  && (wb_q.dst  != '0);

    load_use = ex_live && ex_q.memtoreg &&
               ((id_use_rs && id_rs == ex_q.dst) ||
                (id_use_rt && id_rt == ex_q.dst));

    freeze = mem_busy;
    // A taken branch makes the ID instruction wrong-path, so it wins over the
    // load-use stall. Nothing moves while frozen, so no control is issued.
    stall       = !reset && !freeze && load_use && !ex_pcsrc;
    if_id_flush = !reset && !freeze && (ex_pcsrc || (id_jump && !load_use));
    id_ex_flush = !reset && !freeze && (ex_pcsrc || load_use);

    // dst is never $0 for a live writer, so $0 sources fall through to 00.
    fwd_a = fwd_sel(ex_q.rs, mem_live, mem_q, wb_live, wb_q);
    fwd_b = fwd_sel(ex_q.rt, mem_live, mem_q, wb_live, wb_q);
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!freeze) begin
      wb_d  = mem_q;
      mem_d = '{valid: ex_q.valid, regwrite: ex_q.regwrite,
                memtoreg: ex_q.memtoreg, dst: ex_q.dst};
      if (id_ex_flush)
        ex_d = '0;
      else
        ex_d = '{valid: 1'b1, rs: id_rs, rt: id_rt, regwrite: id_regwrite,
                 memtoreg: id_memtoreg, dst: id_writereg};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;

  // stall/flush are already gated by freeze, so no extra freeze term needed.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    freeze_cnt_d = freeze_cnt_q;
    if (stall && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 1'b1;
    if ((if_id_flush || id_ex_flush) && flush_cnt_q != '1)
      flush_cnt_d = flush_cnt_q + 1'b1;
    if (freeze && freeze_cnt_q != '1)
      freeze_cnt_d = freeze_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign freeze_cnt = freeze_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

  logic       clk, reset;
  logic [4:0] id_rs, id_rt, id_writereg;
  logic       id_use_rs, id_use_rt, id_regwrite, id_memtoreg, id_jump;
  logic       ex_pcsrc, mem_busy;
  logic       stall, freeze, if_id_flush, id_ex_flush;
  logic [1:0] fwd_a, fwd_b;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, freeze_cnt;
`endif

  hazard_unit dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg), .id_writereg(id_writereg),
    .id_jump(id_jump), .ex_pcsrc(ex_pcsrc), .mem_busy(mem_busy),
    .stall(stall), .freeze(freeze), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cmp = 0;
  int mism = 0;

  // Reference model: list of in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct {
    bit         v;
    logic [4:0] rs, rt, dst;
    bit         rw, ld;
  } ins_t;
  ins_t pm[3];
  int m_stall = 0, m_flush = 0, m_freeze = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp++;
    assert (got === exp) else begin
      mism++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit writes(int i);
    return pm[i].v && pm[i].rw && pm[i].dst != 5'd0;
  endfunction

  function automatic bit m_lu();
    if (!writes(0) || !pm[0].ld) return 1'b0;
    return (id_use_rs && id_rs == pm[0].dst) || (id_use_rt && id_rt == pm[0].dst);
  endfunction

  function automatic logic [1:0] m_fwd(logic [4:0] s);
    if (s == 5'd0) return 2'd0;
    if (writes(1) && !pm[1].ld && pm[1].dst == s) return 2'd2;
    if (writes(2) && pm[2].dst == s) return 2'd1;
    return 2'd0;
  endfunction

  function automatic bit e_stall();  return !mem_busy && m_lu() && !ex_pcsrc; endfunction
  function automatic bit e_ifid();   return !mem_busy && (ex_pcsrc || (id_jump && !m_lu())); endfunction
  function automatic bit e_idex();   return !mem_busy && (ex_pcsrc || m_lu()); endfunction

  task automatic clear_model();
    for (int i = 0; i < 3; i++) pm[i] = '{v: 0, rs: 0, rt: 0, dst: 0, rw: 0, ld: 0};
    m_stall = 0; m_flush = 0; m_freeze = 0;
  endtask

  // Apply one ID instruction plus control, then compare against the model.
  task automatic drive(input logic [4:0] rs, rt, input bit urs, urt, rw, ld,
                       input logic [4:0] dst, input bit jmp, pc, busy);
    id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_regwrite = rw; id_memtoreg = ld; id_writereg = dst;
    id_jump = jmp; ex_pcsrc = pc; mem_busy = busy;
    #2;
    chk("freeze", freeze, mem_busy);
    chk("stall", stall, e_stall());
    chk("if_id_flush", if_id_flush, e_ifid());
    chk("id_ex_flush", id_ex_flush, e_idex());
    chk("fwd_a", fwd_a, m_fwd(pm[0].rs));
    chk("fwd_b", fwd_b, m_fwd(pm[0].rt));
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    bit fl, st, fz;
    fl = e_idex(); st = e_stall(); fz = mem_busy;
    @(posedge clk);
    if (fz) m_freeze++;
    else begin
      if (st) m_stall++;
      if (fl || e_ifid()) m_flush++;
      pm[2] = pm[1];
      pm[1] = pm[0];
      if (fl) pm[0] = '{v: 0, rs: 0, rt: 0, dst: 0, rw: 0, ld: 0};
      else    pm[0] = '{v: 1, rs: id_rs, rt: id_rt, dst: id_writereg,
                        rw: id_regwrite, ld: id_memtoreg};
    end
    #1;
  endtask

  initial begin
    clear_model();
    reset = 1'b1;
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_regwrite = 0;
    id_memtoreg = 0; id_writereg = 0;
    id_jump = 1'b1; ex_pcsrc = 1'b1; mem_busy = 1'b1;
    #3;
    chk("rst_freeze", freeze, 1);
    chk("rst_stall", stall, 0);
    chk("rst_if_id_flush", if_id_flush, 0);
    chk("rst_id_ex_flush", id_ex_flush, 0);
    chk("rst_fwd_a", fwd_a, 0);
    chk("rst_fwd_b", fwd_b, 0);
    repeat (2) @(posedge clk);
    #1;
    id_jump = 0; ex_pcsrc = 0; mem_busy = 0;
    reset = 1'b0;

    // lw $2,0($1); add $3,$2,$4 with memory busy 3 cycles
    drive(1, 0, 1, 0, 1, 1, 2, 0, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(2, 4, 1, 1, 1, 0, 3, 0, 0, 1);
      chk("frz_stall", stall, 0);
      tick();
    end
    drive(2, 4, 1, 1, 1, 0, 3, 0, 0, 0);
    chk("lu_stall", stall, 1);
    chk("lu_id_ex_flush", id_ex_flush, 1);
    tick();
    drive(2, 4, 1, 1, 1, 0, 3, 0, 0, 0);
    chk("lu_once", stall, 0);
    tick();
    nop();
    chk("lu_fwd_a", fwd_a, 2'b01);
`ifdef HAZARD_PERF_EN
    chk("freeze_cnt", freeze_cnt, 3);
    chk("stall_cnt", stall_cnt, 1);
`endif
    tick();

    // add $2,$1,$1; sub $5,$2,$2
    drive(1, 1, 1, 1, 1, 0, 2, 0, 0, 0); tick();
    drive(2, 2, 1, 1, 1, 0, 5, 0, 0, 0);
    chk("alu_nostall", stall, 0);
    tick();
    nop();
    chk("alu_fwd_a", fwd_a, 2'b10);
    chk("alu_fwd_b", fwd_b, 2'b10);
    tick();

    // add $2; or $2; and $6,$2,$0
    drive(1, 1, 1, 1, 1, 0, 2, 0, 0, 0); tick();
    drive(1, 1, 1, 1, 1, 0, 2, 0, 0, 0); tick();
    drive(2, 0, 1, 1, 1, 0, 6, 0, 0, 0); tick();
    nop();
    chk("prio_fwd_a", fwd_a, 2'b10);
    chk("zero_fwd_b", fwd_b, 2'b00);
    tick();

    // taken branch coincident with a load-use in ID
    drive(1, 0, 1, 0, 1, 1, 7, 0, 0, 0); tick();
    drive(7, 0, 1, 0, 1, 0, 8, 0, 1, 0);
    chk("br_stall", stall, 0);
    chk("br_if_id_flush", if_id_flush, 1);
    chk("br_id_ex_flush", id_ex_flush, 1);
    tick();
    nop(); tick();
    nop(); tick();

    // jal then reader of $31
    drive(0, 0, 0, 0, 1, 0, 31, 1, 0, 0);
    chk("jal_if_id_flush", if_id_flush, 1);
    chk("jal_id_ex_flush", id_ex_flush, 0);
    tick();
    drive(31, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("jal_noflush", if_id_flush, 0);
    tick();
    nop();
    chk("jal_fwd_a", fwd_a, 2'b10);
    tick();

    // randomized traffic on a small register set to provoke hazards
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 3), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0);
      tick();
    end
`ifdef HAZARD_PERF_EN
    chk("rnd_stall_cnt", stall_cnt, m_stall);
    chk("rnd_flush_cnt", flush_cnt, m_flush);
    chk("rnd_freeze_cnt", freeze_cnt, m_freeze);
`endif

    // asynchronous reset mid-operation
    drive(1, 1, 1, 1, 1, 0, 2, 0, 0, 0); tick();
    drive(2, 2, 1, 1, 1, 0, 5, 0, 0, 0); tick();
    drive(1, 0, 1, 0, 1, 0, 9, 0, 1, 0);
    chk("pre_rst_fwd_a", fwd_a, 2'b10);
    reset = 1'b1;
    #1;
    chk("mid_rst_fwd_a", fwd_a, 0);
    chk("mid_rst_fwd_b", fwd_b, 0);
    chk("mid_rst_if_id_flush", if_id_flush, 0);
    chk("mid_rst_id_ex_flush", id_ex_flush, 0);
    clear_model();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int n = 0; n < 60; n++) begin
      drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 5) == 0);
      tick();
    end
`ifdef HAZARD_PERF_EN
    chk("end_stall_cnt", stall_cnt, m_stall);
    chk("end_flush_cnt", flush_cnt, m_flush);
    chk("end_freeze_cnt", freeze_cnt, m_freeze);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end

endmodule
